// File: rtl/dcache_pkg.sv
// Shared types for the data-cache uncached path.
// Request bundle presented by the LSU to the uncached response unit.
package dcache_pkg;

  typedef struct packed {
    logic        ce;
    logic        we;
    logic        uncache;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [2:0]  req_type;
    logic [31:0] data;
  } mem_dcache_rreq_t;

endpackage

// File: rtl/dcache_uncache_resp.sv
// Uncached load/store sequencer between the LSU and the bus.
// One transaction in flight; flushed loads finish on the bus silently.
module dcache_uncache_resp
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  mem_dcache_rreq_t      dcache_rreq_i,
  output logic                  dcache_ready_o,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rd_req_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic [2:0]            rd_type_o,
  input  logic                  rd_rdy_i,
  input  logic                  ret_valid_i,
  input  logic [DATA_WIDTH-1:0] ret_data_i,
  output logic                  wr_req_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [3:0]            wr_wstrb_o,
  output logic [DATA_WIDTH-1:0] wr_data_o,
  input  logic                  wr_rdy_i,
  input  logic                  wr_done_i
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_REQ  = 3'd1;
  localparam logic [2:0] RD_WAIT = 3'd2;
  localparam logic [2:0] WR_REQ  = 3'd3;
  localparam logic [2:0] WR_WAIT = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            sel;
  logic [2:0]            rtype;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  drop;
  logic                  accept;
  logic                  unused_bits;

  assign unused_bits = dcache_rreq_i.uncache;

  // Ready only when idle and the previous load pulse has gone out.
  assign dcache_ready_o = !rst && (state == IDLE) && !rvalid_o;
  assign accept = dcache_rreq_i.ce && dcache_ready_o && !flush;

  // Bus-side outputs are driven only in their request states.
  always_comb begin
    rd_req_o   = (state == RD_REQ);
    wr_req_o   = (state == WR_REQ);
    rd_addr_o  = rd_req_o ? addr : '0;
    rd_type_o  = rd_req_o ? rtype : '0;
    wr_addr_o  = wr_req_o ? addr : '0;
    wr_wstrb_o = wr_req_o ? sel : '0;
    wr_data_o  = wr_req_o ? wdata : '0;
  end

  // Transaction sequencer, request latch and load-return register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      addr     <= '0;
      sel      <= '0;
      rtype    <= '0;
      wdata    <= '0;
      drop     <= 1'b0;
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: begin
          drop <= 1'b0;
          if (accept) begin
            addr  <= dcache_rreq_i.addr[ADDR_WIDTH-1:0];
            sel   <= dcache_rreq_i.sel;
            rtype <= dcache_rreq_i.req_type;
            wdata <= dcache_rreq_i.data[DATA_WIDTH-1:0];
            state <= dcache_rreq_i.we ? WR_REQ : RD_REQ;
          end
        end
        RD_REQ: begin
          if (flush) drop <= 1'b1;
          if (rd_rdy_i) state <= RD_WAIT;
        end
        RD_WAIT: begin
          if (flush) drop <= 1'b1;
          if (ret_valid_i) begin
            rdata_o  <= ret_data_i;
            rvalid_o <= !(drop || flush);
            drop     <= 1'b0;
            state    <= IDLE;
          end
        end
        WR_REQ: begin
          if (wr_rdy_i) state <= WR_WAIT;
        end
        WR_WAIT: begin
          if (wr_done_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_uncache_resp.sv
// Testbench for dcache_uncache_resp: vector table plus directed sequences.
// Load data expectations flow through a scoreboard queue.
module tb_dcache_uncache_resp;
  import dcache_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  mem_dcache_rreq_t req;
  logic             ready, rvalid;
  logic [31:0]      rdata;
  logic             rd_req, rd_rdy, ret_valid;
  logic [31:0]      rd_addr, ret_data;
  logic [2:0]       rd_type;
  logic             wr_req, wr_rdy, wr_done;
  logic [31:0]      wr_addr, wr_data;
  logic [3:0]       wr_wstrb;

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [2:0]  typ;
    logic [31:0] data;
    int          rdy_dly;
    int          ret_dly;
    int          flush_at;
    logic        exp_rv;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dcache_uncache_resp dut (
    .clk(clk), .rst(rst), .flush(flush),
    .dcache_rreq_i(req), .dcache_ready_o(ready),
    .rvalid_o(rvalid), .rdata_o(rdata),
    .rd_req_o(rd_req), .rd_addr_o(rd_addr),
    .rd_type_o(rd_type), .rd_rdy_i(rd_rdy),
    .ret_valid_i(ret_valid), .ret_data_i(ret_data),
    .wr_req_o(wr_req), .wr_addr_o(wr_addr),
    .wr_wstrb_o(wr_wstrb), .wr_data_o(wr_data),
    .wr_rdy_i(wr_rdy), .wr_done_i(wr_done)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Scoreboard: every rvalid pulse must match the oldest expected load.
  always @(posedge clk) begin
    #1;
    if (rvalid === 1'b1) begin
      if (exp_q.size() == 0) check("sb_spurious_rvalid", 1, 0);
      else check("sb_rdata", rdata, exp_q.pop_front());
    end
  end

  function automatic mem_dcache_rreq_t mk_req(input vec_t v);
    mem_dcache_rreq_t r;
    r.ce = 1'b1;
    r.we = v.we;
    r.uncache = 1'b1;
    r.addr = v.addr;
    r.sel = v.sel;
    r.req_type = v.typ;
    r.data = v.data;
    return r;
  endfunction

  task automatic issue(input vec_t v, output int acc);
    int n = 0;
    req = mk_req(v);
    while (!ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) check("accept_timeout", 0, 1);
    @(posedge clk); #1;
    acc = cyc;
    req.ce = 1'b0;
  endtask

  task automatic serve_read(input vec_t v, input int acc);
    int n = 0;
    while (!rd_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rd_req) begin
      check("rd_req_timeout", 0, 1);
      return;
    end
    check("rd_addr", rd_addr, v.addr);
    check("rd_type", rd_type, v.typ);
    check("rd_excl_wr", wr_req, 0);
    for (int i = 0; i < v.rdy_dly; i++) begin
      if (v.flush_at == 1 && i == 0) flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("rd_hold_req", rd_req, 1);
      check("rd_hold_addr", rd_addr, v.addr);
      check("rd_hold_type", rd_type, v.typ);
    end
    rd_rdy = 1'b1;
    @(posedge clk); #1;
    rd_rdy = 1'b0;
    check("rd_req_done", rd_req, 0);
    if (v.flush_at == 2) flush = 1'b1;
    for (int i = 0; i < v.ret_dly; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      check("rd_wait_busy", ready, 0);
    end
    ret_valid = 1'b1;
    ret_data = v.data;
    @(posedge clk); #1;
    ret_valid = 1'b0;
    flush = 1'b0;
    check("rvalid", rvalid, v.exp_rv);
    if (v.exp_rv) begin
      check("rdata", rdata, v.exp_data);
      check("busy_on_pulse", ready, 0);
      if (v.rdy_dly == 0 && v.ret_dly == 0)
        check("load_latency", cyc - acc, 2);
    end
    @(posedge clk); #1;
    check("rvalid_one_cycle", rvalid, 0);
    check("ready_after_rd", ready, 1);
  endtask

  task automatic serve_write(input vec_t v);
    int n = 0;
    while (!wr_req && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!wr_req) begin
      check("wr_req_timeout", 0, 1);
      return;
    end
    check("wr_addr", wr_addr, v.addr);
    check("wr_wstrb", wr_wstrb, v.sel);
    check("wr_data", wr_data, v.data);
    check("wr_excl_rd", rd_req, 0);
    for (int i = 0; i < v.rdy_dly; i++) begin
      @(posedge clk); #1;
      check("wr_hold_req", wr_req, 1);
      check("wr_hold_addr", wr_addr, v.addr);
      check("wr_hold_strb", wr_wstrb, v.sel);
      check("wr_hold_data", wr_data, v.data);
      check("wr_stall_busy", ready, 0);
    end
    wr_rdy = 1'b1;
    @(posedge clk); #1;
    wr_rdy = 1'b0;
    check("wr_req_done", wr_req, 0);
    if (v.flush_at != 0) flush = 1'b1;
    for (int i = 0; i < v.ret_dly; i++) begin
      @(posedge clk); #1;
      flush = 1'b0;
      check("wr_wait_busy", ready, 0);
      check("wr_wait_no_rd", rd_req, 0);
    end
    wr_done = 1'b1;
    @(posedge clk); #1;
    wr_done = 1'b0;
    flush = 1'b0;
    check("ready_after_wr", ready, 1);
    check("wr_no_rvalid", rvalid, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_rvalid"}, rvalid, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_req"}, wr_req, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_strb"}, wr_wstrb, 0);
    check({tag, "_wr_data"}, wr_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  initial begin
    int acc;
    vec_t st, ld;

    vecs[0] = '{1'b0, 32'h1FD0_0010, 4'hF, 3'b010, 32'hDEAD_BEEF,
                0, 0, 0, 1'b1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h1FD0_0003, 4'b1000, 3'b000, 32'h7700_0000,
                3, 2, 0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 32'h1FD0_0020, 4'hF, 3'b010, 32'h1234_5678,
                0, 5, 2, 1'b0, 32'h0};
    vecs[3] = '{1'b0, 32'h1FD0_0101, 4'b0010, 3'b000, 32'hA5A5_5A5A,
                2, 1, 0, 1'b1, 32'hA5A5_5A5A};
    vecs[4] = '{1'b1, 32'h1FD0_0040, 4'hF, 3'b010, 32'hCAFE_F00D,
                0, 0, 1, 1'b0, 32'h0};
    vecs[5] = '{1'b0, 32'h1FD0_0082, 4'b1100, 3'b001, 32'h0BAD_C0DE,
                2, 3, 1, 1'b0, 32'h0};
    vecs[6] = '{1'b0, 32'h1FD0_0006, 4'b1100, 3'b001, 32'h55AA_0FF0,
                1, 3, 0, 1'b1, 32'h55AA_0FF0};

    rst = 1'b1;
    flush = 1'b0;
    req = '0;
    rd_rdy = 1'b0;
    ret_valid = 1'b0;
    ret_data = '0;
    wr_rdy = 1'b0;
    wr_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_post_reset", ready, 1);

    for (int k = 0; k < 7; k++) begin
      if (vecs[k].exp_rv) exp_q.push_back(vecs[k].exp_data);
      issue(vecs[k], acc);
      if (vecs[k].we) serve_write(vecs[k]);
      else serve_read(vecs[k], acc);
    end

    // Disabled request: ce=0 with we=1 must not start anything.
    req = mk_req(vecs[1]);
    req.ce = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("ce0_no_wr", wr_req, 0);
      check("ce0_no_rd", rd_req, 0);
      check("ce0_ready", ready, 1);
    end

    // Flush while idle blocks acceptance.
    req = mk_req(vecs[0]);
    flush = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("flush_idle_no_rd", rd_req, 0);
    end
    flush = 1'b0;
    req.ce = 1'b0;
    @(posedge clk); #1;
    check("flush_idle_still_idle", rd_req, 0);

    // Store then load to the same address, load held pending.
    st = vecs[1];
    st.addr = 32'h1FD0_0200;
    st.rdy_dly = 1;
    st.ret_dly = 3;
    ld = vecs[0];
    ld.addr = 32'h1FD0_0200;
    ld.data = 32'h0102_0304;
    ld.exp_data = 32'h0102_0304;
    issue(st, acc);
    req = mk_req(ld);
    exp_q.push_back(ld.exp_data);
    serve_write(st);
    check("b2b_rd_after_done", rd_req, 0);
    @(posedge clk); #1;
    acc = cyc;
    req.ce = 1'b0;
    check("b2b_rd_req", rd_req, 1);
    serve_read(ld, acc);

    // Reset in RD_WAIT abandons the load; stray responses ignored.
    ld = vecs[0];
    ld.data = 32'h9999_8888;
    issue(ld, acc);
    check("rst_mid_rd_req", rd_req, 1);
    rd_rdy = 1'b1;
    @(posedge clk); #1;
    rd_rdy = 1'b0;
    check("rst_mid_in_wait", rd_req, 0);
    rst = 1'b1;
    #1;
    check_all_zero("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    ret_valid = 1'b1;
    ret_data = 32'h9999_8888;
    wr_done = 1'b1;
    @(posedge clk); #1;
    ret_valid = 1'b0;
    wr_done = 1'b0;
    check("stray_no_rvalid", rvalid, 0);
    check("stray_ready", ready, 1);
    @(posedge clk); #1;
    check("stray_no_rvalid2", rvalid, 0);
    check("stray_no_wr", wr_req, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dcache_uncache_resp.md
DCACHE_UNCACHE_RESP -- requirements
Module: dcache_uncache_resp

Interface
REQ-001 Parameters, one per line: name, default, meaning:
  ADDR_WIDTH, 32, address width.
  DATA_WIDTH, 32, data width.
REQ-002 Ports, one per line: name, direction, width, meaning:
  clk  in  1  clock.
  rst  in  1  reset; asynchronous, active-high.
  flush  in  1  pipeline flush.
  dcache_rreq_i  in  mem_dcache_rreq_t  request with fields ce, we, uncache, addr[31:0], sel[3:0], req_type[2:0], data[31:0].
  dcache_ready_o  out  1  can accept a request this cycle.
  rvalid_o  out  1  load data valid, one-cycle pulse.
  rdata_o  out  32  load data, full word.
  rd_req_o  out  1  bus read request.
  rd_addr_o  out  32  bus read address.
  rd_type_o  out  3  bus read size (req_type).
  rd_rdy_i  in  1  bus accepts the read.
  ret_valid_i  in  1  read data returned.
  ret_data_i  in  32  read data.
  wr_req_o  out  1  bus write request.
  wr_addr_o  out  32  bus write address.
  wr_wstrb_o  out  4  byte strobes.
  wr_data_o  out  32  write data.
  wr_rdy_i  in  1  bus accepts the write.
  wr_done_i  in  1  write response, completion.

Function
REQ-003 A request SHALL be valid when dcache_rreq_i.ce=1; we=0 means load and we=1 means store; ce=0 SHALL be ignored.
REQ-004 A request SHALL be accepted on a rising edge where the request is valid and dcache_ready_o=1; address, sel, type, data and we SHALL be latched at acceptance.
REQ-005 The FSM SHALL have five states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
REQ-006 IDLE SHALL transition to RD_REQ on an accepted load, or to WR_REQ on an accepted store.
REQ-007 RD_REQ SHALL assert rd_req_o with the latched addr/type, hold it stable until rd_rdy_i=1, then transition to RD_WAIT.
REQ-008 RD_WAIT SHALL wait for ret_valid_i; in that cycle it SHALL register ret_data_i to rdata_o, pulse rvalid_o the next cycle, and return to IDLE.
REQ-009 WR_REQ SHALL assert wr_req_o with wr_addr_o=addr, wr_wstrb_o=sel, wr_data_o=data, hold them stable until wr_rdy_i=1, then transition to WR_WAIT.
REQ-010 WR_WAIT SHALL return to IDLE on wr_done_i; no rvalid_o SHALL be produced for stores.
REQ-011 dcache_ready_o SHALL be 1 only in IDLE with no pending rvalid_o pulse, so at most one transaction is outstanding; a store therefore completes (wr_done_i) before any later request is accepted.
REQ-012 Minimum load latency SHALL be: accept at edge N; rd_req_o high in cycle N+1; with rd_rdy_i=1 in that cycle and ret_valid_i=1 in cycle N+2, rvalid_o high in cycle N+3.
REQ-013 When flush=1 in IDLE, no request SHALL be accepted.
REQ-014 When flush=1 in RD_REQ or RD_WAIT, the bus read SHALL run to completion, a sticky drop flag SHALL be set, and the resulting rvalid_o SHALL be suppressed; the flag SHALL clear on return to IDLE.
REQ-015 When flush=1 during WR_REQ or WR_WAIT, the store SHALL still complete, since it was already committed.
REQ-016 ret_valid_i and wr_done_i arriving outside their wait states SHALL be ignored.
REQ-017 rd_req_o and wr_req_o SHALL never be asserted in the same cycle.

Reset
REQ-018 While rst=1, asynchronously: FSM=IDLE, dcache_ready_o=0, rvalid_o=0, rdata_o=0, rd_req_o=0, wr_req_o=0, all address/data/strobe outputs=0, drop flag=0.
REQ-019 dcache_ready_o SHALL be 1 from the first clock after rst deasserts.
REQ-020 Reset asserted mid-transaction SHALL abandon it without a response.

Verification
REQ-021 Load: addr=0x1FD0_0010, type=010; rd_rdy_i immediate; ret_data_i=0xDEADBEEF one cycle later -> rvalid_o=1 with rdata_o=0xDEADBEEF in cycle N+3, dcache_ready_o=1 in cycle N+4.
REQ-022 Store byte: addr=0x1FD0_0003, sel=1000, data=0x7700_0000; wr_rdy_i delayed 3 cycles -> wr outputs stable across the stall, ready=0 until the cycle after wr_done_i, no rvalid_o.
REQ-023 Load followed by flush in RD_WAIT, ret_valid_i 5 cycles later -> rd transaction completes, rvalid_o stays 0, ready returns to 1.
REQ-024 Back-to-back store then load to the same address -> the load's rd_req_o is asserted only after wr_done_i.
REQ-025 rst pulsed while in RD_WAIT -> all outputs 0 immediately; a later stray ret_valid_i produces no rvalid_o.
REQ-026 Request with ce=0 and we=1 -> ignored; FSM stays IDLE and no bus activity occurs.
